// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Four-requester round-robin arbiter driving a shared, registered data mux.
// A grant lasts while the grantee keeps its request high, up to MAX_HOLD
// consecutive cycles. Every grant is followed by one RELEASE cycle and one
// IDLE cycle before the next grant can be issued. Priority rotates: the search
// for the next winner starts just after the last requester that was served.
//
// Parameters
//   WIDTH     bit width of each requester data word
//   MAX_HOLD  maximum consecutive GRANT cycles per grant, legal range 1..15
//
// Ports
//   clk    in   1         single clock, all state changes on the rising edge
//   reset  in   1         synchronous, active-high reset
//   req    in   4         level-sensitive request lines, bit i = requester i
//   din    in   4*WIDTH   packed data, requester i at [i*WIDTH +: WIDTH]
//   gnt    out  4         registered one-hot grant, zero when nobody is granted
//   sel    out  2         registered mux select, current or last grantee
//   dout   out  WIDTH     registered mux output, din slice chosen by sel
//   valid  out  1         registered, dout carries the grantee's data
//   busy   out  1         high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic [WIDTH-1:0]   dout,
  output logic               valid,
  output logic               busy
);

  localparam int NUM_REQ = 4;

  // Hold counter value on the last permitted GRANT cycle. The counter is
  // 4 bits wide, which covers the whole legal MAX_HOLD range of 1..15.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_reg, state_next;
  logic [3:0]         gnt_reg,   gnt_next;
  logic [1:0]         sel_reg,   sel_next;
  logic [WIDTH-1:0]   dout_reg,  dout_next;
  logic               valid_reg, valid_next;
  logic [3:0]         hold_reg,  hold_next;
  logic [1:0]         last_reg,  last_next;

  // ---------------------------------------------------------------------------
  // Per-requester views: data slices and the rotated search order
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   din_slice  [NUM_REQ];
  logic [1:0]         search_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;
  logic [1:0]         winner;
  logic [NUM_REQ-1:0] winner_onehot;
  logic               any_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign din_slice[gi]  = din[gi*WIDTH +: WIDTH];
      // Position gi of the search visits requester (last + 1 + gi) mod 4;
      // the 2-bit add provides the wrap for free.
      assign search_idx[gi] = last_reg + 2'(gi + 1);
      assign rot_req[gi]    = req[search_idx[gi]];
      assign winner_onehot[gi] = (winner == 2'(gi));
    end
  endgenerate

  assign any_req = |req;

  // Lowest set position in the rotated view is the winner. Scanning from the
  // top down lets the lowest position overwrite the others.
  always_comb begin
    winner = search_idx[0];
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        winner = search_idx[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grant termination
  // ---------------------------------------------------------------------------
  logic req_held;
  logic hold_done;
  logic grant_exit;

  assign req_held   = req[sel_reg];
  assign hold_done  = (hold_reg == HOLD_LAST);
  // Either condition (or both together) ends the grant with one transition.
  assign grant_exit = !req_held || hold_done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      hold_reg  <= '0;
      // Last grantee = 3 makes requester 0 first in line after reset.
      last_reg  <= 2'd3;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      dout_reg  <= dout_next;
      valid_reg <= valid_next;
      hold_reg  <= hold_next;
      last_reg  <= last_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    dout_next  = dout_reg;
    valid_next = valid_reg;
    hold_next  = hold_reg;
    last_next  = last_reg;

    case (state_reg)
      IDLE: begin
        gnt_next   = '0;
        valid_next = 1'b0;
        if (any_req) begin
          state_next = GRANT;
          gnt_next   = winner_onehot;
          sel_next   = winner;
          hold_next  = '0;
        end
      end

      GRANT: begin
        // Only the selected slice reaches dout; other requesters' data is
        // never looked at, so they cannot disturb the output.
        dout_next  = din_slice[sel_reg];
        valid_next = 1'b1;
        hold_next  = hold_reg + 4'd1;
        if (grant_exit) begin
          state_next = RELEASE;
          gnt_next   = '0;
          last_next  = sel_reg;
        end
      end

      RELEASE: begin
        gnt_next   = '0;
        valid_next = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt   = gnt_reg;
  assign sel   = sel_reg;
  assign dout  = dout_reg;
  assign valid = valid_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//
// Two arbiters share the same stimulus: one with MAX_HOLD = 4 and one with
// MAX_HOLD = 1. A behavioural model per arbiter tracks who owns the mux, how
// long the grant has lasted and whether the post-grant gap is still running;
// every cycle all outputs of both arbiters are compared with it. Directed
// scenarios come first, then randomized requests, data and resets.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req;
  logic [4*W-1:0] din;

  logic [3:0]     gnt0, gnt1;
  logic [1:0]     sel0, sel1;
  logic [W-1:0]   dout0, dout1;
  logic           valid0, valid1;
  logic           busy0, busy1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .din   (din),
    .gnt   (gnt0),
    .sel   (sel0),
    .dout  (dout0),
    .valid (valid0),
    .busy  (busy0)
  );

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .din   (din),
    .gnt   (gnt1),
    .sel   (sel1),
    .dout  (dout1),
    .valid (valid1),
    .busy  (busy1)
  );

  always #5 clk = ~clk;

  // Unpacked view of the data bus for the model.
  logic [W-1:0] din_s [4];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      din_s[i] = din[i*W +: W];
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: owner of the mux (-1 = nobody), grant length so far,
  // cycles of enforced gap remaining after a grant, last served requester.
  // ---------------------------------------------------------------------------
  int           m_owner [2] = '{-1, -1};
  int           m_len   [2] = '{0, 0};
  int           m_cool  [2] = '{0, 0};
  int           m_last  [2] = '{3, 3};
  bit           m_new   [2] = '{1'b0, 1'b0};
  int           e_sel   [2] = '{0, 0};
  logic [W-1:0] e_dout  [2] = '{'0, '0};
  bit           e_valid [2] = '{1'b0, 1'b0};

  function automatic int max_hold(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic logic [3:0] exp_gnt(input int u);
    logic [3:0] r;
    int o;
    r = '0;
    o = m_owner[u];
    if (o >= 0) r[o[1:0]] = 1'b1;
    return r;
  endfunction

  function automatic bit exp_busy(input int u);
    return (m_owner[u] >= 0) || (m_cool[u] > 0);
  endfunction

  task automatic model_edge(input int u);
    int c;
    int o;
    m_new[u] = 1'b0;
    if (reset) begin
      m_owner[u] = -1;
      m_len[u]   = 0;
      m_cool[u]  = 0;
      m_last[u]  = 3;
      e_sel[u]   = 0;
      e_dout[u]  = '0;
      e_valid[u] = 1'b0;
    end else if (m_owner[u] >= 0) begin
      o = m_owner[u];
      e_dout[u]  = din_s[o[1:0]];
      e_valid[u] = 1'b1;
      m_len[u]   = m_len[u] + 1;
      if (!req[o[1:0]] || m_len[u] == max_hold(u)) begin
        m_last[u]  = o;
        m_owner[u] = -1;
        m_cool[u]  = 1;
      end
    end else if (m_cool[u] > 0) begin
      m_cool[u]  = 0;
      e_valid[u] = 1'b0;
    end else begin
      e_valid[u] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last[u] + k) % 4;
        if (req[c[1:0]] && m_owner[u] < 0) begin
          m_owner[u] = c;
          m_len[u]   = 0;
          e_sel[u]   = c;
          m_new[u]   = 1'b1;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("u0_gnt",     32'(gnt0),            32'(exp_gnt(0)));
    check("u0_sel",     32'(sel0),            32'(e_sel[0]));
    check("u0_dout",    32'(dout0),           32'(e_dout[0]));
    check("u0_valid",   32'(valid0),          32'(e_valid[0]));
    check("u0_busy",    32'(busy0),           32'(exp_busy(0)));
    check("u0_onehot0", 32'($onehot0(gnt0)),  32'd1);
    check("u1_gnt",     32'(gnt1),            32'(exp_gnt(1)));
    check("u1_sel",     32'(sel1),            32'(e_sel[1]));
    check("u1_dout",    32'(dout1),           32'(e_dout[1]));
    check("u1_valid",   32'(valid1),          32'(e_valid[1]));
    check("u1_busy",    32'(busy1),           32'(exp_busy(1)));
    check("u1_onehot0", 32'($onehot0(gnt1)),  32'd1);
  endtask

  // One clock: DUTs and model advance on the rising edge, outputs are
  // compared on the falling edge, new inputs are driven after that.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    @(negedge clk);
    if (m_new[0]) $display("cyc=%0d dut0 grant -> requester %0d", cyc, m_owner[0]);
    compare_all();
  endtask

  // Waits (bounded) for the MAX_HOLD=4 model to start a grant to requester r.
  task automatic wait_grant_to(input int r, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_new[0] && m_owner[0] == r) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    req   = '0;
    din   = '0;

    // Reset held for several cycles: outputs sit at reset values.
    repeat (3) step();
    check("rst_gnt",   32'(gnt0),   32'h0);
    check("rst_sel",   32'(sel0),   32'h0);
    check("rst_dout",  32'(dout0),  32'h0);
    check("rst_valid", 32'(valid0), 32'h0);
    check("rst_busy",  32'(busy0),  32'h0);

    // Single requester 0 with constant data 0xA.
    reset = 1'b0;
    req   = 4'b0001;
    din   = 16'h000A;
    step();
    check("first_gnt", 32'(gnt0), 32'h1);
    step();
    check("first_valid", 32'(valid0), 32'h1);
    check("first_dout",  32'(dout0),  32'hA);
    repeat (2) step();
    check("hold4_gnt", 32'(gnt0), 32'h1);
    step();
    check("release_gnt",   32'(gnt0),   32'h0);
    check("release_busy",  32'(busy0),  32'h1);
    check("release_valid", 32'(valid0), 32'h1);
    step();
    check("idle_busy",  32'(busy0),  32'h0);
    check("idle_valid", 32'(valid0), 32'h0);
    step();
    check("regrant_gnt", 32'(gnt0), 32'h1);

    // All four requesting continuously.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      din = 16'($urandom);
      step();
    end

    // Requester 2 drops its request after two GRANT cycles; 3 is next.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b1111;
    wait_grant_to(2, "wait_grant2");
    step();
    req = 4'b1000;
    step();
    check("drop_gnt",   32'(gnt0),   32'h0);
    check("drop_valid", 32'(valid0), 32'h1);
    step();
    check("drop_valid_low", 32'(valid0), 32'h0);
    step();
    check("next_gnt3", 32'(gnt0), 32'h8);

    // Requester 0 pulses and its data changes while 1 holds the grant.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b0010;
    din   = 16'h5C30;
    step();
    check("g1_gnt", 32'(gnt0), 32'h2);
    step();
    req = 4'b0011;
    din[3:0] = ~din[3:0];
    step();
    check("nopreempt_gnt_a", 32'(gnt0), 32'h2);
    check("nopreempt_dout_a", 32'(dout0), 32'h3);
    req = 4'b0010;
    din[3:0] = ~din[3:0];
    step();
    check("nopreempt_gnt_b", 32'(gnt0), 32'h2);
    check("nopreempt_dout_b", 32'(dout0), 32'h3);
    req = 4'b0011;
    step();
    check("g1_end_gnt", 32'(gnt0), 32'h0);
    step();
    step();
    check("wrap_gnt0", 32'(gnt0), 32'h1);

    // Reset in the second GRANT cycle of requester 2.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b1111;
    din   = 16'hBEEF;
    wait_grant_to(2, "wait_grant2_rst");
    step();
    reset = 1'b1;
    step();
    check("midrst_gnt",   32'(gnt0),   32'h0);
    check("midrst_sel",   32'(sel0),   32'h0);
    check("midrst_dout",  32'(dout0),  32'h0);
    check("midrst_valid", 32'(valid0), 32'h0);
    check("midrst_busy",  32'(busy0),  32'h0);
    reset = 1'b0;
    step();
    check("postrst_gnt", 32'(gnt0), 32'h1);

    // Randomized requests, data and occasional resets.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      din   = 16'($urandom);
      reset = ($urandom_range(63) == 0);
      step();
    end
    reset = 1'b0;
    req   = '0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, bit width of each requester data word.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive GRANT cycles per grant (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  request lines, bit i = requester i; level-sensitive.
REQ-006 din  input  4*WIDTH  packed requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-008 sel  output  2  registered select of shared mux, index of current or last grantee.
REQ-009 dout  output  WIDTH  registered shared-mux output, din slice selected by sel.
REQ-010 valid  output  1  registered; dout carries grantee data.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states: IDLE, GRANT, RELEASE; 2-bit state register.
REQ-013 IDLE: if req != 0 at edge N, winner = first set bit searching from (last+1) mod 4 upward with wrap; at N+1 state = GRANT, gnt = one-hot(winner), sel = winner, hold counter = 0.
REQ-014 IDLE with req == 0: remain IDLE, gnt = 0, sel unchanged.
REQ-015 GRANT: each edge, dout <= din slice[sel], valid <= 1, hold counter += 1 (4-bit, saturating not required given exit rule).
REQ-016 GRANT exit: if req[sel] == 0 sampled, or hold counter == MAX_HOLD-1, next state = RELEASE, gnt <= 0, last <= sel.
REQ-017 Both exit conditions in the same cycle: single transition to RELEASE, no double update.
REQ-018 Latency: req at edge N -> gnt at N+1 -> valid/dout at N+2; dout at edge K reflects din sampled at edge K.
REQ-019 RELEASE: exactly one cycle; valid <= 0, gnt = 0; next state IDLE unconditionally.
REQ-020 Minimum turnaround between two grants: 2 idle-grant cycles (RELEASE, IDLE); no back-to-back grants.
REQ-021 Round-robin fairness: a requester holding req high is granted within 3 other grants.
REQ-022 Wrap: last = 3 -> search order 0,1,2,3; last = 1 -> 2,3,0,1.
REQ-023 Request from non-grantee during GRANT: ignored until IDLE; no preemption.
REQ-024 Changes on din of non-selected requesters never affect dout.
REQ-025 gnt always zero or one-hot; gnt != 0 only in GRANT state.
REQ-026 MAX_HOLD = 1: each grant lasts exactly one GRANT cycle.

Reset
REQ-027 reset high at edge: state = IDLE, gnt = 0, sel = 0, dout = 0, valid = 0, busy = 0, hold counter = 0, last = 3.
REQ-028 reset overrides all activity including mid-GRANT; no RELEASE cycle emitted; priority restarts at requester 0.
REQ-029 reset held multiple cycles: outputs stay at reset values; first grant possible on edge after reset deasserts.

Verification
REQ-030 Reset then req=0001, din slice0=0xA held -> gnt=0001 at N+1, valid=1 dout=0xA at N+2, gnt stays 0001 4 cycles (MAX_HOLD=4), then RELEASE, IDLE, regrant 0001.
REQ-031 req=1111 constant -> grant sequence 0001,0010,0100,1000,0001, each 4 GRANT cycles separated by RELEASE+IDLE.
REQ-032 Grantee 2 drops req after 2 GRANT cycles -> RELEASE next edge, gnt=0, valid=0 following edge; next grant to 3 if requesting, else 0.
REQ-033 During grant to 1, pulse req[0] and change din slice0 -> gnt and dout unaffected; 0 granted only after wrap.
REQ-034 Assert reset in 2nd GRANT cycle of requester 2 -> next edge all outputs zero; req=1111 afterwards grants 0001 first.
REQ-035 Every cycle of every scenario: gnt zero or one-hot, busy == (state != IDLE), valid implies gnt was nonzero previous cycle.
